// File: rtl/fetch_pc_pkg.sv
// Shared types, branch-condition codes and the condition evaluator
// for the fetch / program-counter unit.
package fetch_pc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HALT = 2'b10
    } fetch_state_t;

    localparam logic [1:0] kBrAlways = 2'b00;
    localparam logic [1:0] kBrEq     = 2'b01;
    localparam logic [1:0] kBrLt     = 2'b10;
    localparam logic [1:0] kBrNe     = 2'b11;

    // True when the registered flags satisfy the branch condition code.
    function automatic logic cond_met(input logic [1:0] cond,
                                      input logic       z,
                                      input logic       n);
        logic met;
        case (cond)
            kBrAlways: met = 1'b1;
            kBrEq:     met = z;
            kBrLt:     met = n;
            kBrNe:     met = ~z;
            default:   met = 1'b0;
        endcase
        return met;
    endfunction

endpackage

// File: rtl/fetch_pc_branch_resolve.sv
// Combinational branch resolver: decides whether a branch is taken and
// produces the following PC (sequential, absolute or PC-relative).
// PW must be larger than 8 so the 8-bit operand can be extended.
module branch_resolve
    import fetch_pc_pkg::*;
#(
    parameter int PW = 10
) (
    input  logic [1:0]    cond,
    input  logic          z,
    input  logic          n,
    input  logic          conditional_jump,
    input  logic          branch_abs_or_rel,
    input  logic [7:0]    target,
    input  logic [PW-1:0] pc,
    output logic          taken,
    output logic [PW-1:0] next_pc
);

    logic [PW-1:0] target_zext_s;
    logic [PW-1:0] target_sext_s;

    assign target_zext_s = {{(PW-8){1'b0}}, target};
    assign target_sext_s = {{(PW-8){target[7]}}, target};

    // Select the next PC; all arithmetic wraps modulo 2**PW.
    always_comb begin
        taken   = conditional_jump & cond_met(cond, z, n);
        next_pc = pc + {{(PW-1){1'b0}}, 1'b1};
        if (taken) begin
            if (branch_abs_or_rel) begin
                next_pc = pc + target_sext_s;
            end else begin
                next_pc = target_zext_s;
            end
        end else begin
            next_pc = pc + {{(PW-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/fetch_pc.sv
// Program counter / fetch unit: IDLE/RUN/HALT program sequencing,
// PC register, compare flags and a saturating retired-instruction counter.
// Every output is a flop; Start acts as the synchronous clear.
module fetch_pc
    import fetch_pc_pkg::*;
#(
    parameter int PW = 10,
    parameter int CW = 16
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic          Ack,
    input  logic          ConditionalJump,
    input  logic          BranchAbsOrRel,
    input  logic [1:0]    BranchConditions,
    input  logic          CmpEn,
    input  logic          ZeroIn,
    input  logic          NegIn,
    input  logic [7:0]    Target,
    output logic [PW-1:0] ProgCtr,
    output logic          Running,
    output logic          Done,
    output logic [CW-1:0] InstCount
);

    fetch_state_t  state_r;
    fetch_state_t  state_nxt_s;
    logic [PW-1:0] pc_r;
    logic [PW-1:0] pc_nxt_s;
    logic          z_r;
    logic          z_nxt_s;
    logic          n_r;
    logic          n_nxt_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_nxt_s;
    logic          running_r;
    logic          done_r;
    logic          taken_s;
    logic [PW-1:0] branch_pc_s;

    branch_resolve #(
        .PW (PW)
    ) u_branch_resolve (
        .cond              (BranchConditions),
        .z                 (z_r),
        .n                 (n_r),
        .conditional_jump  (ConditionalJump),
        .branch_abs_or_rel (BranchAbsOrRel),
        .target            (Target),
        .pc                (pc_r),
        .taken             (taken_s),
        .next_pc           (branch_pc_s)
    );

    // Next-state, next-PC, flag and counter logic; Start overrides everything.
    always_comb begin
        state_nxt_s = state_r;
        pc_nxt_s    = pc_r;
        z_nxt_s     = z_r;
        n_nxt_s     = n_r;
        cnt_nxt_s   = cnt_r;
        if (Start) begin
            state_nxt_s = IDLE;
            pc_nxt_s    = {PW{1'b0}};
            z_nxt_s     = 1'b0;
            n_nxt_s     = 1'b0;
            cnt_nxt_s   = {CW{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    state_nxt_s = RUN;
                end
                RUN: begin
                    // Every RUN cycle retires one instruction, halt included.
                    if (cnt_r != {CW{1'b1}}) begin
                        cnt_nxt_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    end else begin
                        cnt_nxt_s = cnt_r;
                    end
                    // The branch above already used the old flags.
                    if (CmpEn) begin
                        z_nxt_s = ZeroIn;
                        n_nxt_s = NegIn;
                    end else begin
                        z_nxt_s = z_r;
                        n_nxt_s = n_r;
                    end
                    // Halt wins over a simultaneous branch.
                    if (Ack) begin
                        state_nxt_s = HALT;
                        pc_nxt_s    = pc_r;
                    end else begin
                        state_nxt_s = RUN;
                        pc_nxt_s    = branch_pc_s;
                    end
                end
                HALT: begin
                    state_nxt_s = HALT;
                end
                default: begin
                    state_nxt_s = IDLE;
                    pc_nxt_s    = {PW{1'b0}};
                    z_nxt_s     = 1'b0;
                    n_nxt_s     = 1'b0;
                    cnt_nxt_s   = {CW{1'b0}};
                end
            endcase
        end
    end

    // State, PC, flags, counter and registered status outputs.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_r   <= IDLE;
            pc_r      <= {PW{1'b0}};
            z_r       <= 1'b0;
            n_r       <= 1'b0;
            cnt_r     <= {CW{1'b0}};
            running_r <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            pc_r      <= pc_nxt_s;
            z_r       <= z_nxt_s;
            n_r       <= n_nxt_s;
            cnt_r     <= cnt_nxt_s;
            running_r <= (state_nxt_s == RUN);
            done_r    <= (state_nxt_s == HALT);
        end
    end

    assign ProgCtr   = pc_r;
    assign Running   = running_r;
    assign Done      = done_r;
    assign InstCount = cnt_r;

endmodule

// File: tb/tb_fetch_pc.sv
// Bench for fetch_pc: directed scenarios followed by random traffic, all
// checked against a cycle-level behavioural model of the program counter.
module tb_fetch_pc;

    localparam int PW     = 10;
    localparam int CW     = 6;
    localparam int PC_MOD = 1 << PW;
    localparam int CNT_MAX = (1 << CW) - 1;
    localparam int S_IDLE = 0;
    localparam int S_RUN  = 1;
    localparam int S_HALT = 2;

    logic          clk;
    logic          reset;
    logic          start;
    logic          ack;
    logic          cj;
    logic          rel;
    logic [1:0]    cond;
    logic          cmp_en;
    logic          zero_in;
    logic          neg_in;
    logic [7:0]    target;
    logic [PW-1:0] prog_ctr;
    logic          running;
    logic          done;
    logic [CW-1:0] inst_count;

    int compared   = 0;
    int mismatched = 0;

    // Reference model state
    int m_state;
    int m_pc;
    int m_z;
    int m_n;
    int m_cnt;

    fetch_pc #(
        .PW (PW),
        .CW (CW)
    ) dut (
        .Clk              (clk),
        .Reset            (reset),
        .Start            (start),
        .Ack              (ack),
        .ConditionalJump  (cj),
        .BranchAbsOrRel   (rel),
        .BranchConditions (cond),
        .CmpEn            (cmp_en),
        .ZeroIn           (zero_in),
        .NegIn            (neg_in),
        .Target           (target),
        .ProgCtr          (prog_ctr),
        .Running          (running),
        .Done             (done),
        .InstCount        (inst_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = S_IDLE;
        m_pc    = 0;
        m_z     = 0;
        m_n     = 0;
        m_cnt   = 0;
    endtask

    // One rising edge of the behavioural model, using the current inputs.
    task automatic model_edge();
        int  off;
        bit  ok;
        if (start) begin
            model_reset();
        end else if (m_state == S_IDLE) begin
            m_state = S_RUN;
        end else if (m_state == S_RUN) begin
            case (int'(cond))
                0:       ok = 1'b1;
                1:       ok = (m_z == 1);
                2:       ok = (m_n == 1);
                default: ok = (m_z == 0);
            endcase
            if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
            if (ack) begin
                m_state = S_HALT;
            end else if (cj && ok) begin
                if (rel) begin
                    off  = (int'(target) >= 128) ? int'(target) - 256 : int'(target);
                    m_pc = ((m_pc + off) % PC_MOD + PC_MOD) % PC_MOD;
                end else begin
                    m_pc = int'(target);
                end
            end else begin
                m_pc = (m_pc + 1) % PC_MOD;
            end
            if (cmp_en) begin
                m_z = int'(zero_in);
                m_n = int'(neg_in);
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pc"},      32'(prog_ctr),   32'(m_pc));
        chk({tag, ".running"}, 32'(running),    32'(m_state == S_RUN));
        chk({tag, ".done"},    32'(done),       32'(m_state == S_HALT));
        chk({tag, ".count"},   32'(inst_count), 32'(m_cnt));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic idle_inputs();
        start   = 1'b0;
        ack     = 1'b0;
        cj      = 1'b0;
        rel     = 1'b0;
        cond    = 2'b00;
        cmp_en  = 1'b0;
        zero_in = 1'b0;
        neg_in  = 1'b0;
        target  = 8'h00;
    endtask

    task automatic branch(input logic r, input logic [1:0] c, input logic [7:0] t);
        idle_inputs();
        cj     = 1'b1;
        rel    = r;
        cond   = c;
        target = t;
    endtask

    initial begin
        int gap;
        idle_inputs();
        reset = 1'b0;
        model_reset();
        #3;
        check_all("reset");

        // Start held for two cycles, then released
        #4 reset = 1'b1;
        start = 1'b1;
        step("start0");
        step("start1");
        start = 1'b0;
        step("idle_to_run");
        chk("run_entry_pc", 32'(prog_ctr), 32'd0);
        for (int i = 0; i < 4; i++) step("seq");
        chk("seq_pc4", 32'(prog_ctr), 32'd4);
        chk("seq_cnt4", 32'(inst_count), 32'd4);

        // Relative branches from PC 20
        branch(1'b0, 2'b00, 8'd20);
        step("abs20");
        branch(1'b1, 2'b00, 8'hF6);
        step("rel_neg");
        chk("rel_neg_pc", 32'(prog_ctr), 32'd10);
        branch(1'b0, 2'b00, 8'd20);
        step("abs20b");
        branch(1'b1, 2'b00, 8'h05);
        step("rel_pos");
        chk("rel_pos_pc", 32'(prog_ctr), 32'd25);

        // CMP Z=1 then BEQ absolute 0x40
        idle_inputs();
        cmp_en = 1'b1; zero_in = 1'b1;
        step("cmp_z1");
        branch(1'b0, 2'b01, 8'h40);
        step("beq_taken");
        chk("beq_taken_pc", 32'(prog_ctr), 32'd64);
        idle_inputs();
        cmp_en = 1'b1; zero_in = 1'b0;
        step("cmp_z0");
        branch(1'b0, 2'b01, 8'h40);
        step("beq_not");
        chk("beq_not_pc", 32'(prog_ctr), 32'd66);

        // Same-cycle CMP and BEQ sees old Z=0, new Z visible next cycle
        branch(1'b0, 2'b01, 8'h30);
        cmp_en = 1'b1; zero_in = 1'b1;
        step("cmp_br_same");
        chk("cmp_br_same_pc", 32'(prog_ctr), 32'd67);
        branch(1'b0, 2'b01, 8'h30);
        step("z_now_set");
        chk("z_now_set_pc", 32'(prog_ctr), 32'h30);

        // Counter saturation
        idle_inputs();
        for (int i = 0; i < 70; i++) step("sat");
        chk("sat_cnt", 32'(inst_count), 32'(CNT_MAX));

        // Halt at PC 7 with a simultaneous branch request
        branch(1'b0, 2'b00, 8'd7);
        step("abs7");
        branch(1'b0, 2'b00, 8'd99);
        ack = 1'b1;
        step("ack");
        chk("halt_done", 32'(done), 32'd1);
        chk("halt_pc", 32'(prog_ctr), 32'd7);
        for (int i = 0; i < 10; i++) begin
            branch(1'($urandom), 2'($urandom), 8'($urandom));
            ack = 1'($urandom);
            cmp_en = 1'($urandom);
            step("halt_hold");
        end
        chk("halt_hold_pc", 32'(prog_ctr), 32'd7);
        idle_inputs();
        start = 1'b1;
        step("restart");
        chk("restart_pc", 32'(prog_ctr), 32'd0);
        chk("restart_done", 32'(done), 32'd0);
        start = 1'b0;
        step("rerun");

        // Walk the PC to 1023 with relative jumps, then wrap
        for (int i = 0; i < 20 && m_pc != PC_MOD - 1; i++) begin
            gap = PC_MOD - 1 - m_pc;
            branch(1'b1, 2'b00, 8'((gap > 127) ? 127 : gap));
            step("walk");
        end
        chk("walk_pc", 32'(prog_ctr), 32'(PC_MOD - 1));
        idle_inputs();
        step("wrap");
        chk("wrap_pc", 32'(prog_ctr), 32'd0);

        // Asynchronous reset between edges
        step("pre_async");
        #2 reset = 1'b0;
        model_reset();
        #1;
        check_all("async_reset");
        chk("async_pc", 32'(prog_ctr), 32'd0);
        #1 reset = 1'b1;

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            idle_inputs();
            start   = ($urandom_range(0, 39) == 0) ||
                      (m_state == S_HALT && $urandom_range(0, 3) == 0);
            ack     = ($urandom_range(0, 24) == 0);
            cj      = 1'($urandom);
            rel     = 1'($urandom);
            cond    = 2'($urandom);
            cmp_en  = ($urandom_range(0, 2) == 0);
            zero_in = 1'($urandom);
            neg_in  = 1'($urandom);
            target  = 8'($urandom);
            step("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
